// File: rtl/tlc_pkg.sv
// Shared definitions for the intersection light sequencer.
//   - state codes (legacy localparam form plus an enum view for debug/tools)
//   - lamp encodings, {R,Y,G} one-hot
//   - default intervals in Timer units
//   - lamps_for(): lamp pattern shown while a given state is active
package tlc_pkg;

  localparam logic [2:0] S_MG   = 3'd0;
  localparam logic [2:0] S_MY   = 3'd1;
  localparam logic [2:0] S_WALK = 3'd2;
  localparam logic [2:0] S_SG   = 3'd3;
  localparam logic [2:0] S_SX   = 3'd4;
  localparam logic [2:0] S_SY   = 3'd5;

  typedef enum logic [2:0] {
    MG   = S_MG,
    MY   = S_MY,
    WALK = S_WALK,
    SG   = S_SG,
    SX   = S_SX,
    SY   = S_SY
  } tlc_state_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [3:0] T_BASE_DEF = 4'd6;
  localparam logic [3:0] T_EXT_DEF  = 4'd3;
  localparam logic [3:0] T_YEL_DEF  = 4'd2;

  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
  } lamp_set_t;

  // Unknown codes fall back to all-red so no direction is ever released by accident.
  function automatic lamp_set_t lamps_for(input logic [2:0] st);
    lamp_set_t ls;
    ls = '{main: LAMP_R, side: LAMP_R, walk: 1'b0};
    case (st)
      S_MG:    ls = '{main: LAMP_G, side: LAMP_R, walk: 1'b0};
      S_MY:    ls = '{main: LAMP_Y, side: LAMP_R, walk: 1'b0};
      S_WALK:  ls = '{main: LAMP_R, side: LAMP_R, walk: 1'b1};
      S_SG:    ls = '{main: LAMP_R, side: LAMP_G, walk: 1'b0};
      S_SX:    ls = '{main: LAMP_R, side: LAMP_G, walk: 1'b0};
      S_SY:    ls = '{main: LAMP_R, side: LAMP_Y, walk: 1'b0};
      default: ls = '{main: LAMP_R, side: LAMP_R, walk: 1'b0};
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/interval_arm_guard.sv
// Masks the Timer's expired level around each start_timer pulse.
// The Timer loads on the edge that samples start_timer, so during the pulse
// cycle expired still reflects the previous interval, and the cycle after is
// kept masked as well. expired_ok_o is only asserted from the second cycle
// after a pulse onward.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   start_i      start_timer pulse as seen by the Timer
//   expired_i    raw expired level from the Timer
//   expired_ok_o expired, qualified by the arm window
module interval_arm_guard
  import tlc_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic expired_i,
  output logic expired_ok_o
);

  // Down-counter for the masked cycles remaining after the pulse cycle.
  logic [1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (start_i) begin
      hold_cnt_d = 2'd1;
    end else if (hold_cnt_q != 2'd0) begin
      hold_cnt_d = hold_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt_q <= 2'd0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign expired_ok_o = expired_i & ~start_i & (hold_cnt_q == 2'd0);

endmodule

// File: rtl/traffic_light_sequencer.sv
// Intersection light FSM. Arms the Timer with an interval (Value + one-cycle
// start_timer pulse) on every state entry and advances when expired is seen
// outside the arm window. Drives main/side lamps and the walk lamp.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   MG    | main green, side red; re-arms itself unless side/walk demand
//   MY    | main yellow; goes to WALK if a request is pending, else SG
//   WALK  | all red, walk lamp on
//   SG    | side green; one extension if a vehicle is still present
//   SX    | side green extension (never re-extended)
//   SY    | side yellow, then back to MG
//
// Ports:
//   clk          system clock
//   Reset_Sync   synchronous active-high reset
//   Sensor       side-street vehicle present
//   Walk_Request pedestrian button
//   expired      Timer interval elapsed (level)
//   Value        interval handed to the Timer
//   start_timer  one-cycle Timer load pulse
//   Main_Lights  main lamps {R,Y,G}
//   Side_Lights  side lamps {R,Y,G}
//   Walk_Lamp    pedestrian walk lamp
module traffic_light_sequencer
  import tlc_pkg::*;
#(
  parameter logic [3:0] T_BASE = T_BASE_DEF,
  parameter logic [3:0] T_EXT  = T_EXT_DEF,
  parameter logic [3:0] T_YEL  = T_YEL_DEF
) (
  input  logic       clk,
  input  logic       Reset_Sync,
  input  logic       Sensor,
  input  logic       Walk_Request,
  input  logic       expired,
  output logic [3:0] Value,
  output logic       start_timer,
  output logic [2:0] Main_Lights,
  output logic [2:0] Side_Lights,
  output logic       Walk_Lamp
);

  logic [2:0] state_q, state_d;
  logic       arm_q, arm_d;            // first cycle after reset: issue the MG arm pulse
  logic       walk_pending_q, walk_pending_d;
  logic [3:0] value_q, value_d;
  logic       start_q, start_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;
  logic       walk_lamp_q, walk_lamp_d;

  logic       expired_ok;
  logic       enter;
  logic [2:0] next_state;
  lamp_set_t  next_lamps;

  interval_arm_guard u_guard (
    .clk_i        (clk),
    .rst_i        (Reset_Sync),
    .start_i      (start_q),
    .expired_i    (expired),
    .expired_ok_o (expired_ok)
  );

  function automatic logic [3:0] interval_for(input logic [2:0] st);
    logic [3:0] iv;
    case (st)
      S_MG, S_SG:   iv = T_BASE;
      S_MY, S_SY:   iv = T_YEL;
      S_WALK, S_SX: iv = T_EXT;
      default:      iv = T_BASE;
    endcase
    return iv;
  endfunction

  always_comb begin
    state_d        = state_q;
    arm_d          = 1'b0;
    walk_pending_d = walk_pending_q | Walk_Request;
    value_d        = value_q;
    start_d        = 1'b0;
    main_d         = main_q;
    side_d         = side_q;
    walk_lamp_d    = walk_lamp_q;
    enter          = 1'b0;
    next_state     = state_q;

    if (arm_q) begin
      enter      = 1'b1;
      next_state = S_MG;
    end else begin
      case (state_q)
        S_MG: if (expired_ok) begin
          enter      = 1'b1;
          next_state = (Sensor | walk_pending_q) ? S_MY : S_MG;
        end
        S_MY: if (expired_ok) begin
          enter      = 1'b1;
          next_state = walk_pending_q ? S_WALK : S_SG;
        end
        S_WALK: if (expired_ok) begin
          enter      = 1'b1;
          next_state = S_SG;
        end
        S_SG: if (expired_ok) begin
          enter      = 1'b1;
          next_state = Sensor ? S_SX : S_SY;
        end
        S_SX: if (expired_ok) begin
          enter      = 1'b1;
          next_state = S_SY;
        end
        S_SY: if (expired_ok) begin
          enter      = 1'b1;
          next_state = S_MG;
        end
        default: begin
          // Corrupted state: same as a reset, then arm MG on the following edge.
          state_d        = S_MG;
          arm_d          = 1'b1;
          walk_pending_d = 1'b0;
          value_d        = T_BASE;
          main_d         = LAMP_G;
          side_d         = LAMP_R;
          walk_lamp_d    = 1'b0;
        end
      endcase
    end

    next_lamps = lamps_for(next_state);

    if (enter) begin
      state_d     = next_state;
      value_d     = interval_for(next_state);
      start_d     = 1'b1;
      main_d      = next_lamps.main;
      side_d      = next_lamps.side;
      walk_lamp_d = next_lamps.walk;
      // Entering WALK serves the request, including one arriving on this same edge.
      if (next_state == S_WALK) begin
        walk_pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      state_q        <= S_MG;
      arm_q          <= 1'b1;
      walk_pending_q <= 1'b0;
      value_q        <= T_BASE;
      start_q        <= 1'b0;
      main_q         <= LAMP_G;
      side_q         <= LAMP_R;
      walk_lamp_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      arm_q          <= arm_d;
      walk_pending_q <= walk_pending_d;
      value_q        <= value_d;
      start_q        <= start_d;
      main_q         <= main_d;
      side_q         <= side_d;
      walk_lamp_q    <= walk_lamp_d;
    end
  end

  assign Value       = value_q;
  assign start_timer = start_q;
  assign Main_Lights = main_q;
  assign Side_Lights = side_q;
  assign Walk_Lamp   = walk_lamp_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
module tb_traffic_light_sequencer;

  logic       clk = 1'b0;
  logic       Reset_Sync = 1'b0;
  logic       Sensor = 1'b0;
  logic       Walk_Request = 1'b0;
  logic       expired;
  logic [3:0] Value;
  logic       start_timer;
  logic [2:0] Main_Lights;
  logic [2:0] Side_Lights;
  logic       Walk_Lamp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_light_sequencer #(
    .T_BASE (4'd6),
    .T_EXT  (4'd3),
    .T_YEL  (4'd2)
  ) dut (
    .clk          (clk),
    .Reset_Sync   (Reset_Sync),
    .Sensor       (Sensor),
    .Walk_Request (Walk_Request),
    .expired      (expired),
    .Value        (Value),
    .start_timer  (start_timer),
    .Main_Lights  (Main_Lights),
    .Side_Lights  (Side_Lights),
    .Walk_Lamp    (Walk_Lamp)
  );

  // Timer: loads Value on start_timer, counts down on each tick, expired while zero.
  logic       tick = 1'b1;
  logic [3:0] tcount = 4'd0;
  always @(posedge clk) begin
    if (start_timer) tcount <= Value;
    else if (tick && tcount != 4'd0) tcount <= tcount - 4'd1;
  end
  assign expired = (tcount == 4'd0);

  // Never two directions released at once.
  logic inv_en = 1'b0;
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      assert (Main_Lights == 3'b100 || Side_Lights == 3'b100)
      else begin
        failures++;
        $display("FAIL both_non_red: got main=%b side=%b, want at least one 100", Main_Lights, Side_Lights);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_out(input string nm, input logic st, input logic [3:0] v,
                         input logic [2:0] m, input logic [2:0] s, input logic w);
    checks++;
    if (start_timer !== st || Value !== v || Main_Lights !== m || Side_Lights !== s || Walk_Lamp !== w) begin
      failures++;
      $display("FAIL %s: got st=%b val=%0d main=%b side=%b walk=%b, want st=%b val=%0d main=%b side=%b walk=%b",
               nm, start_timer, Value, Main_Lights, Side_Lights, Walk_Lamp, st, v, m, s, w);
    end
  endtask

  // Called on the negedge of a pulse cycle; waits (bounded) for the next pulse and checks it.
  task automatic expect_pulse(input string nm, input logic s_in, input logic w_in, input logic [3:0] v,
                              input logic [2:0] m, input logic [2:0] s, input logic w);
    int n;
    n = 0;
    Sensor = s_in;
    Walk_Request = w_in;
    @(negedge clk);
    Walk_Request = 1'b0;
    while (!start_timer && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk_out(nm, 1'b1, v, m, s, w);
  endtask

  typedef struct packed {
    logic       sens;
    logic       walk;
    logic [3:0] v;
    logic [2:0] m;
    logic [2:0] s;
    logic       wl;
  } vec_t;

  vec_t tbl [13];

  // Reference model: intervals and lamps per state, transitions by rule.
  typedef enum int {M_MG = 0, M_MY = 1, M_WALK = 2, M_SG = 3, M_SX = 4, M_SY = 5} mst_t;
  logic [3:0] m_ivl  [6];
  logic [2:0] m_main [6];
  logic [2:0] m_side [6];
  logic       m_wlk  [6];

  function automatic mst_t next_of(input mst_t s, input logic sens, input logic pend);
    case (s)
      M_MG:    return (sens || pend) ? M_MY : M_MG;
      M_MY:    return pend ? M_WALK : M_SG;
      M_WALK:  return M_SG;
      M_SG:    return sens ? M_SX : M_SY;
      M_SX:    return M_SY;
      default: return M_MG;
    endcase
  endfunction

  mst_t       m_state;
  int         m_since;
  logic       m_pending;
  logic       m_init;
  logic       e_st;
  logic [3:0] e_v;
  logic [2:0] e_m;
  logic [2:0] e_s;
  logic       e_w;

  task automatic m_enter(input mst_t x);
    m_state = x;
    m_since = 0;
    e_st = 1'b1;
    e_v  = m_ivl[x];
    e_m  = m_main[x];
    e_s  = m_side[x];
    e_w  = m_wlk[x];
  endtask

  initial begin
    int n;
    logic [3:0] v0;
    mst_t nx;

    m_ivl  = '{4'd6, 4'd2, 4'd3, 4'd6, 4'd3, 4'd2};
    m_main = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    m_side = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
    m_wlk  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    //            sens  walk  val    main    side    walk
    tbl[0]  = '{1'b0, 1'b0, 4'd6, 3'b001, 3'b100, 1'b0};  // MG re-arm
    tbl[1]  = '{1'b0, 1'b0, 4'd6, 3'b001, 3'b100, 1'b0};  // MG re-arm
    tbl[2]  = '{1'b1, 1'b0, 4'd2, 3'b010, 3'b100, 1'b0};  // MY
    tbl[3]  = '{1'b1, 1'b0, 4'd6, 3'b100, 3'b001, 1'b0};  // SG
    tbl[4]  = '{1'b1, 1'b0, 4'd3, 3'b100, 3'b001, 1'b0};  // SX
    tbl[5]  = '{1'b1, 1'b0, 4'd2, 3'b100, 3'b010, 1'b0};  // SY (no re-extension)
    tbl[6]  = '{1'b0, 1'b0, 4'd6, 3'b001, 3'b100, 1'b0};  // MG
    tbl[7]  = '{1'b0, 1'b1, 4'd2, 3'b010, 3'b100, 1'b0};  // MY from walk request
    tbl[8]  = '{1'b0, 1'b0, 4'd3, 3'b100, 3'b100, 1'b1};  // WALK
    tbl[9]  = '{1'b0, 1'b0, 4'd6, 3'b100, 3'b001, 1'b0};  // SG
    tbl[10] = '{1'b0, 1'b0, 4'd2, 3'b100, 3'b010, 1'b0};  // SY
    tbl[11] = '{1'b0, 1'b0, 4'd6, 3'b001, 3'b100, 1'b0};  // MG
    tbl[12] = '{1'b0, 1'b0, 4'd6, 3'b001, 3'b100, 1'b0};  // MG re-arm, request was served

    // 1. reset values, then arm pulse one cycle after release
    tick = 1'b1;
    @(negedge clk);
    Reset_Sync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    inv_en = 1'b1;
    chk_out("t1_reset", 1'b0, 4'd6, 3'b001, 3'b100, 1'b0);
    Reset_Sync = 1'b0;
    @(negedge clk);
    chk_out("t1_arm", 1'b1, 4'd6, 3'b001, 3'b100, 1'b0);

    // 1-3. main sequencing table
    for (int i = 0; i < 13; i++) begin
      expect_pulse($sformatf("row%0d", i), tbl[i].sens, tbl[i].walk, tbl[i].v, tbl[i].m, tbl[i].s, tbl[i].wl);
    end

    // 4. request on the WALK entry edge is absorbed
    expect_pulse("t4_my", 1'b0, 1'b1, 4'd2, 3'b010, 3'b100, 1'b0);
    @(negedge clk);
    n = 0;
    while (!expired && n < 20) begin
      @(negedge clk);
      n++;
    end
    Walk_Request = 1'b1;
    @(negedge clk);
    Walk_Request = 1'b0;
    chk_out("t4_walk", 1'b1, 4'd3, 3'b100, 3'b100, 1'b1);
    expect_pulse("t4_sg", 1'b0, 1'b0, 4'd6, 3'b100, 3'b001, 1'b0);
    expect_pulse("t4_sy", 1'b0, 1'b0, 4'd2, 3'b100, 3'b010, 1'b0);
    expect_pulse("t4_mg", 1'b0, 1'b0, 4'd6, 3'b001, 3'b100, 1'b0);
    expect_pulse("t4_rearm", 1'b0, 1'b0, 4'd6, 3'b001, 3'b100, 1'b0);

    // 5. reset during SX drops a pending request
    expect_pulse("t5_my", 1'b1, 1'b0, 4'd2, 3'b010, 3'b100, 1'b0);
    expect_pulse("t5_sg", 1'b1, 1'b0, 4'd6, 3'b100, 3'b001, 1'b0);
    expect_pulse("t5_sx", 1'b1, 1'b0, 4'd3, 3'b100, 3'b001, 1'b0);
    Walk_Request = 1'b1;
    @(negedge clk);
    Walk_Request = 1'b0;
    Reset_Sync = 1'b1;
    @(negedge clk);
    Reset_Sync = 1'b0;
    Sensor = 1'b0;
    chk_out("t5_reset", 1'b0, 4'd6, 3'b001, 3'b100, 1'b0);
    @(negedge clk);
    chk_out("t5_arm", 1'b1, 4'd6, 3'b001, 3'b100, 1'b0);
    expect_pulse("t5_no_walk", 1'b0, 1'b0, 4'd6, 3'b001, 3'b100, 1'b0);

    // 6. stale expired never shortens a dwell: pulse spacing is interval + load + act cycle
    Sensor = 1'b1;
    for (int k = 0; k < 6; k++) begin
      v0 = Value;
      n = 0;
      @(negedge clk);
      n++;
      while (!start_timer && n < 40) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n != int'(v0) + 2) begin
        failures++;
        $display("FAIL t6_dwell%0d: got spacing=%0d, want %0d", k, n, int'(v0) + 2);
      end
    end

    // Randomised run against the reference model
    Reset_Sync = 1'b1;
    Sensor = 1'b0;
    Walk_Request = 1'b0;
    m_state = M_MG;
    m_since = 0;
    m_pending = 1'b0;
    m_init = 1'b1;
    e_st = 1'b0; e_v = 4'd6; e_m = 3'b001; e_s = 3'b100; e_w = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk_out($sformatf("rand_c%0d", c), e_st, e_v, e_m, e_s, e_w);

      Reset_Sync   = (c < 2) ? 1'b1 : ($urandom_range(0, 299) == 0);
      Sensor       = 1'($urandom_range(0, 1));
      Walk_Request = ($urandom_range(0, 15) == 0);
      tick         = 1'($urandom_range(0, 1));

      if (Reset_Sync) begin
        m_state = M_MG; m_since = 0; m_pending = 1'b0; m_init = 1'b1;
        e_st = 1'b0; e_v = 4'd6; e_m = 3'b001; e_s = 3'b100; e_w = 1'b0;
      end else if (m_init) begin
        m_init = 1'b0;
        m_pending = m_pending | Walk_Request;
        m_enter(M_MG);
      end else if (expired && m_since >= 2) begin
        nx = next_of(m_state, Sensor, m_pending);
        m_pending = (m_pending | Walk_Request) && (nx != M_WALK);
        m_enter(nx);
      end else begin
        m_pending = m_pending | Walk_Request;
        m_since++;
        e_st = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
